// File: rtl/collatz_pkg.sv
// Shared widths, limits and the sweep state type for the Collatz sweep controller.
package collatz_pkg;

  localparam int DATA_W = 32;
  localparam int STEP_W = 16;
  localparam logic [STEP_W-1:0] STEP_MAX = 16'hFFFF;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_WAIT   = 3'd2,
    S_REPORT = 3'd3,
    S_FINISH = 3'd4
  } sweep_state_t;

endpackage

// File: rtl/collatz_step_ctr.sv
// Saturating step counter: clear wins over increment, holds once it hits STEP_MAX.
module collatz_step_ctr
  import collatz_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              clr,
  input  logic              inc,
  output logic [STEP_W-1:0] cnt,
  output logic              at_max
);

  logic [STEP_W-1:0] cnt_r;

  // Counter register with synchronous reset and clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_r <= 16'h0000;
    end else if (clr) begin
      cnt_r <= 16'h0000;
    end else if (inc && (cnt_r != STEP_MAX)) begin
      cnt_r <= cnt_r + 16'h0001;
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign cnt    = cnt_r;
  assign at_max = (cnt_r == STEP_MAX);

endmodule

// File: rtl/collatz.sv
// Top-level Collatz sweep controller: walks consecutive start values through the iterator and reports each result.
module collatz_sweep
  import collatz_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [DATA_W-1:0] first_n,
  input  logic [STEP_W-1:0] count,
  output logic              busy,
  output logic              sweep_done,
  output logic              it_go,
  output logic [DATA_W-1:0] it_n,
  input  logic [DATA_W-1:0] it_dout,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [DATA_W-1:0] res_n,
  output logic [STEP_W-1:0] res_steps,
  output logic              res_err
);

  sweep_state_t      state_r, state_s;
  logic [DATA_W-1:0] cur_n_r, cur_n_s;
  logic [STEP_W-1:0] rem_r, rem_s;
  logic [DATA_W-1:0] res_n_r, res_n_s, it_n_r, it_n_s;
  logic [STEP_W-1:0] res_steps_r, res_steps_s;
  logic              res_err_r, res_err_s;
  logic              busy_r, done_r, it_go_r, res_valid_r;
  logic              busy_s, done_s, it_go_s, res_valid_s;
  logic              clr_s, inc_s, at_max_s;
  logic [STEP_W-1:0] step_cnt_s;

  collatz_step_ctr u_step_ctr (
    .clk    (clk),
    .reset  (reset),
    .clr    (clr_s),
    .inc    (inc_s),
    .cnt    (step_cnt_s),
    .at_max (at_max_s)
  );

  // Next-state, datapath and next-output decode; outputs are registered from these.
  always_comb begin
    state_s     = state_r;
    cur_n_s     = cur_n_r;
    rem_s       = rem_r;
    res_n_s     = res_n_r;
    res_steps_s = res_steps_r;
    res_err_s   = res_err_r;
    clr_s       = 1'b0;
    inc_s       = 1'b0;
    case (state_r)
      S_IDLE: begin
        if (start) begin
          cur_n_s = first_n;
          rem_s   = count;
          state_s = (count == 16'h0000) ? S_FINISH : S_LOAD;
        end else begin
          state_s = S_IDLE;
        end
      end
      S_LOAD: begin
        clr_s = 1'b1;
        if (cur_n_r == 32'h0000_0000) begin
          state_s     = S_REPORT;
          res_n_s     = cur_n_r;
          res_steps_s = STEP_MAX;
          res_err_s   = 1'b1;
        end else begin
          state_s = S_WAIT;
        end
      end
      S_WAIT: begin
        if (it_dout == 32'h0000_0001) begin
          state_s     = S_REPORT;
          res_n_s     = cur_n_r;
          res_steps_s = step_cnt_s;
          res_err_s   = 1'b0;
        end else if (at_max_s) begin
          state_s     = S_REPORT;
          res_n_s     = cur_n_r;
          res_steps_s = STEP_MAX;
          res_err_s   = 1'b1;
        end else begin
          inc_s = 1'b1;
        end
      end
      S_REPORT: begin
        if (res_ready) begin
          cur_n_s = cur_n_r + 32'h0000_0001;
          rem_s   = rem_r - 16'h0001;
          state_s = (rem_r > 16'h0001) ? S_LOAD : S_FINISH;
        end else begin
          state_s = S_REPORT;
        end
      end
      S_FINISH: begin
        state_s = S_IDLE;
      end
      default: begin
        state_s = S_IDLE;
      end
    endcase

    busy_s      = (state_s == S_LOAD) || (state_s == S_WAIT) || (state_s == S_REPORT);
    done_s      = (state_s == S_FINISH);
    res_valid_s = (state_s == S_REPORT);
    // A zero start value is reported as an error without ever launching the iterator.
    it_go_s     = (state_s == S_LOAD) && (cur_n_s != 32'h0000_0000);
    if (state_s == S_LOAD) begin
      it_n_s = cur_n_s;
    end else begin
      it_n_s = it_n_r;
    end
  end

  // State, datapath and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= S_IDLE;
      cur_n_r     <= 32'h0000_0000;
      rem_r       <= 16'h0000;
      res_n_r     <= 32'h0000_0000;
      res_steps_r <= 16'h0000;
      res_err_r   <= 1'b0;
      it_n_r      <= 32'h0000_0000;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      it_go_r     <= 1'b0;
      res_valid_r <= 1'b0;
    end else begin
      state_r     <= state_s;
      cur_n_r     <= cur_n_s;
      rem_r       <= rem_s;
      res_n_r     <= res_n_s;
      res_steps_r <= res_steps_s;
      res_err_r   <= res_err_s;
      it_n_r      <= it_n_s;
      busy_r      <= busy_s;
      done_r      <= done_s;
      it_go_r     <= it_go_s;
      res_valid_r <= res_valid_s;
    end
  end

  assign busy       = busy_r;
  assign sweep_done = done_r;
  assign it_go      = it_go_r;
  assign it_n       = it_n_r;
  assign res_valid  = res_valid_r;
  assign res_n      = res_n_r;
  assign res_steps  = res_steps_r;
  assign res_err    = res_err_r;

endmodule

// File: tb/tb_collatz_sweep.sv
// Directed bench for collatz_sweep with a behavioural Collatz iterator and result model.
module tb_collatz_sweep;

  logic        clk = 1'b0;
  logic        reset, start, res_ready;
  logic [31:0] first_n;
  logic [15:0] count;
  logic        busy, sweep_done, it_go, res_valid, res_err;
  logic [31:0] it_n, it_dout, res_n;
  logic [15:0] res_steps;

  always #5 clk = ~clk;

  collatz_sweep dut (
    .clk(clk), .reset(reset), .start(start), .first_n(first_n), .count(count),
    .busy(busy), .sweep_done(sweep_done), .it_go(it_go), .it_n(it_n), .it_dout(it_dout),
    .res_valid(res_valid), .res_ready(res_ready), .res_n(res_n), .res_steps(res_steps),
    .res_err(res_err)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc = 0;
  int go_cnt = 0, done_cnt = 0, go_cyc = 0, done_cyc = 0;
  int stuck_left = 0;

  logic [31:0] go_q[$];
  logic [31:0] en_q[$];
  logic [15:0] es_q[$];
  logic        ee_q[$];
  logic [31:0] on_q[$];
  logic [15:0] os_q[$];
  logic        oe_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural iterator: loads on it_go, then one Collatz step per clock (64-bit internally).
  longint unsigned it_v = 64'd0;
  assign it_dout = it_v[31:0];
  always @(posedge clk) begin
    if (stuck_left > 0)  it_v <= 64'd4;
    else if (it_go)      it_v <= {32'd0, it_n};
    else if (it_v[0])    it_v <= it_v * 64'd3 + 64'd1;
    else                 it_v <= it_v >> 1;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic flag_unexpected(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s: event occurred, expected none", name);
  endtask

  // Model: {err, steps} for one start value, by iterating the Collatz rule directly.
  function automatic logic [16:0] model_steps(input logic [31:0] n);
    longint unsigned v = {32'd0, n};
    int s = 0;
    while (v[31:0] != 32'd1 && s < 65535) begin
      v = v[0] ? v * 64'd3 + 64'd1 : v >> 1;
      s++;
    end
    if (v[31:0] == 32'd1) return {1'b0, 16'(s)};
    return {1'b1, 16'hFFFF};
  endfunction

  task automatic push_model(input logic [31:0] f, input int c, input int stuck, output int nz);
    logic [31:0] n;
    logic [16:0] r;
    nz = 0;
    for (int i = 0; i < c; i++) begin
      n = f + 32'(i);
      if (n == 32'd0) begin
        r = {1'b1, 16'hFFFF};
      end else begin
        go_q.push_back(n);
        nz++;
        r = (i < stuck) ? {1'b1, 16'hFFFF} : model_steps(n);
      end
      en_q.push_back(n);
      es_q.push_back(r[15:0]);
      ee_q.push_back(r[16]);
    end
  endtask

  // Compare process: checks loads, latency, stability under backpressure and every result.
  logic        prev_hold = 1'b0, prev_valid = 1'b0, pe;
  logic [31:0] pn;
  logic [15:0] ps;
  always @(negedge clk) begin
    #1;
    if (reset) begin
      prev_hold  = 1'b0;
      prev_valid = 1'b0;
    end else begin
      if (it_go) begin
        go_cnt++;
        go_cyc = cyc;
        check("go_exclusive_of_valid", res_valid, 1'b0);
        if (go_q.size() == 0) flag_unexpected("unexpected_it_go");
        else check("it_n", it_n, go_q.pop_front());
      end
      if (res_valid && !prev_valid && en_q.size() > 0 && en_q[0] != 32'd0)
        check("latency", 64'(cyc - go_cyc), 64'(es_q[0]) + 64'd2);
      if (res_valid && prev_hold) begin
        check("hold_res_n", res_n, pn);
        check("hold_res_steps", res_steps, ps);
        check("hold_res_err", res_err, pe);
      end
      if (res_valid && res_ready) begin
        if (en_q.size() == 0) begin
          flag_unexpected("unexpected_result");
        end else begin
          check("res_n", res_n, en_q.pop_front());
          check("res_steps", res_steps, es_q.pop_front());
          check("res_err", res_err, ee_q.pop_front());
        end
        on_q.push_back(res_n);
        os_q.push_back(res_steps);
        oe_q.push_back(res_err);
        if (stuck_left > 0) stuck_left--;
      end
      prev_hold  = res_valid && !res_ready;
      prev_valid = res_valid;
      pn = res_n;
      ps = res_steps;
      pe = res_err;
      if (sweep_done) begin
        done_cnt++;
        done_cyc = cyc;
      end
    end
  end

  task automatic clear_queues();
    go_q.delete(); en_q.delete(); es_q.delete(); ee_q.delete();
    on_q.delete(); os_q.delete(); oe_q.delete();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"}, busy, 1'b0);
    check({tag, "_sweep_done"}, sweep_done, 1'b0);
    check({tag, "_it_go"}, it_go, 1'b0);
    check({tag, "_it_n"}, it_n, 32'd0);
    check({tag, "_res_valid"}, res_valid, 1'b0);
    check({tag, "_res_n"}, res_n, 32'd0);
    check({tag, "_res_steps"}, res_steps, 16'd0);
    check({tag, "_res_err"}, res_err, 1'b0);
  endtask

  task automatic check_obs(input int idx, input logic [31:0] n, input logic [15:0] s, input logic e);
    if (idx < on_q.size()) begin
      check("obs_n", on_q[idx], n);
      check("obs_steps", os_q[idx], s);
      check("obs_err", oe_q[idx], e);
    end else begin
      check("obs_missing", 64'(on_q.size()), 64'(idx + 1));
    end
  endtask

  task automatic run_sweep(input logic [31:0] f, input int c, input int hold, input int poke,
                           input int stuck);
    int nz, d0, g0, gs, sc;
    clear_queues();
    push_model(f, c, stuck, nz);
    d0 = done_cnt;
    g0 = go_cnt;
    res_ready  = (hold == 0);
    stuck_left = stuck;
    @(negedge clk);
    start = 1'b1; first_n = f; count = 16'(c); sc = cyc;
    @(negedge clk);
    start = 1'b0; first_n = $urandom; count = 16'($urandom);
    if (c > 0) check("busy_high", busy, 1'b1);
    if (poke > 0) begin
      repeat (poke) @(negedge clk);
      start = 1'b1; first_n = 32'd100; count = 16'd9;
      @(negedge clk);
      start = 1'b0;
    end
    if (hold > 0) begin
      for (int i = 0; i < 400 && !res_valid; i++) @(negedge clk);
      check("valid_before_hold", res_valid, 1'b1);
      gs = go_cnt;
      repeat (hold) @(negedge clk);
      check("valid_held", res_valid, 1'b1);
      check("no_go_while_pending", 64'(go_cnt), 64'(gs));
      check("no_done_while_pending", 64'(done_cnt), 64'(d0));
      res_ready = 1'b1;
    end
    for (int i = 0; i < 70000 && done_cnt == d0; i++) @(negedge clk);
    repeat (3) @(negedge clk);
    check("done_once", 64'(done_cnt - d0), 64'd1);
    check("busy_low_after", busy, 1'b0);
    check("go_count", 64'(go_cnt - g0), 64'(nz));
    check("results_left", 64'(en_q.size()), 64'd0);
    check("loads_left", 64'(go_q.size()), 64'd0);
    if (c == 0) check("count0_done_latency", 64'((done_cyc - sc) <= 2), 64'd1);
  endtask

  initial begin
    int g_snap, d_snap;
    reset = 1'b1; start = 1'b0; first_n = 32'd0; count = 16'd0; res_ready = 1'b1;

    check("model_n1", model_steps(32'd1), {1'b0, 16'd0});
    check("model_n6", model_steps(32'd6), {1'b0, 16'd8});
    check("model_n7", model_steps(32'd7), {1'b0, 16'd16});
    check("model_n27", model_steps(32'd27), {1'b0, 16'd111});

    repeat (2) @(negedge clk);
    check_reset_outputs("reset");
    reset = 1'b0;
    clear_queues();

    run_sweep(32'd6, 1, 0, 0, 0);
    check_obs(0, 32'd6, 16'd8, 1'b0);

    run_sweep(32'd1, 3, 0, 2, 0);
    check("count3_results", 64'(on_q.size()), 64'd3);
    check_obs(0, 32'd1, 16'd0, 1'b0);
    check_obs(1, 32'd2, 16'd1, 1'b0);
    check_obs(2, 32'd3, 16'd7, 1'b0);

    run_sweep(32'd27, 1, 20, 0, 0);
    check_obs(0, 32'd27, 16'd111, 1'b0);

    run_sweep(32'hFFFF_FFFF, 2, 0, 0, 0);
    check_obs(1, 32'd0, 16'hFFFF, 1'b1);

    run_sweep(32'd5, 2, 0, 0, 1);
    check_obs(0, 32'd5, 16'hFFFF, 1'b1);
    check_obs(1, 32'd6, 16'd8, 1'b0);

    run_sweep(32'd1234, 0, 0, 0, 0);

    // Reset in the middle of a long WAIT: sweep is abandoned silently.
    clear_queues();
    go_q.push_back(32'd27);
    res_ready = 1'b1;
    @(negedge clk);
    start = 1'b1; first_n = 32'd27; count = 16'd5;
    @(negedge clk);
    start = 1'b0;
    g_snap = go_cnt;
    for (int i = 0; i < 10 && go_cnt == g_snap; i++) @(negedge clk);
    check("midreset_go_seen", 64'(go_cnt - g_snap), 64'd1);
    repeat (5) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check_reset_outputs("midreset");
    @(negedge clk);
    clear_queues();
    g_snap = go_cnt;
    d_snap = done_cnt;
    reset = 1'b0;
    repeat (10) @(negedge clk);
    check("midreset_no_go", 64'(go_cnt), 64'(g_snap));
    check("midreset_no_done", 64'(done_cnt), 64'(d_snap));

    run_sweep(32'd6, 1, 0, 0, 0);
    check_obs(0, 32'd6, 16'd8, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/collatz_sweep.md
COLLATZ_SWEEP -- requirements
Module: collatz_sweep

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset, named clk and reset.
REQ-002 Port clk, input, 1: rising-edge clock for all state.
REQ-003 Port reset, input, 1: synchronous active-high reset.
REQ-004 Port start, input, 1: begin a sweep; sampled only in IDLE.
REQ-005 Port first_n, input, 32: first start value; captured when start is accepted.
REQ-006 Port count, input, 16: number of consecutive values to sweep; captured with first_n.
REQ-007 Port busy, output, 1: high from the cycle after start is accepted until return to IDLE.
REQ-008 Port sweep_done, output, 1: one-cycle pulse when the sweep ends.
REQ-009 Ports it_go (output, 1) and it_n (output, 32): drive the iterator's go and n inputs.
REQ-010 Port it_dout, input, 32: the iterator's current value.
REQ-011 Ports res_valid (output, 1), res_ready (input, 1), res_n (output, 32), res_steps (output, 16), res_err (output, 1): per-value result channel using a valid/ready handshake.

Function
REQ-012 States SHALL be IDLE, LOAD, WAIT, REPORT and FINISH.
REQ-013 In IDLE with start=1, the block SHALL capture first_n and count into cur_n and remaining, then go to FINISH if count=0, else to LOAD.
REQ-014 In LOAD, the block SHALL assert it_go=1 and it_n=cur_n for exactly one cycle, clear steps to 0, and go to WAIT.
REQ-015 If cur_n=0 in LOAD, the block SHALL NOT assert it_go; it SHALL go directly to REPORT with res_steps=16'hFFFF and res_err=1.
REQ-016 In WAIT, each cycle the block SHALL sample it_dout.
  - If it_dout=1: go to REPORT with res_steps=steps and res_err=0.
  - Otherwise: steps += 1.
REQ-017 The step count is the number of iterations taken to reach 1: n=1 -> 0, n=6 -> 8, n=7 -> 16, n=27 -> 111.
REQ-018 If steps reaches 16'hFFFF in WAIT without it_dout=1, the block SHALL go to REPORT with res_steps=16'hFFFF and res_err=1 (timeout).
REQ-019 In REPORT, res_valid SHALL be high, with res_n, res_steps and res_err held stable, until the cycle in which res_ready=1.
REQ-020 On the handshake in REPORT:
  - cur_n SHALL increment modulo 2^32 (wraps FFFFFFFF -> 0).
  - remaining SHALL decrement.
  - Next state SHALL be LOAD if remaining was >1, else FINISH.
REQ-021 No it_go SHALL be issued while a result is pending; backpressure stalls the sweep indefinitely.
REQ-022 In FINISH, the block SHALL pulse sweep_done for one cycle, deassert busy, and return to IDLE.
REQ-023 A start asserted outside IDLE SHALL be ignored, with no effect on the captured first_n and count.
REQ-024 it_go SHALL be 0 in every state except LOAD.
REQ-025 res_valid SHALL be 0 in every state except REPORT.
REQ-026 Minimum latency per value SHALL be 1 (LOAD) + steps+1 (WAIT) + 1 (REPORT with res_ready=1) cycles.

Reset
REQ-027 On reset, the state SHALL be IDLE.
REQ-028 On reset, the outputs SHALL be: busy=0, sweep_done=0, it_go=0, it_n=0, res_valid=0, res_n=0, res_steps=0, res_err=0.
REQ-029 Reset asserted mid-sweep, in any state, SHALL abandon the sweep without a sweep_done pulse and without a further it_go.
REQ-030 The first accepted start after reset SHALL behave identically to one issued from power-up.

Structure
REQ-031 The shared package collatz_pkg SHALL hold:
  - DATA_W=32, STEP_W=16 and STEP_MAX=16'hFFFF.
  - The sweep state enum type.
REQ-032 The saturating step counter (clear, increment, at-max flag) SHALL be one sub-module, collatz_step_ctr.
REQ-033 All outputs SHALL be registered; no combinational path from it_dout or res_ready to any output.

Verification
REQ-034 start with first_n=6, count=1, res_ready=1, driving a behavioural iterator -> one it_go with it_n=6; result 6/8/err=0; sweep_done pulse; busy returns to 0.
REQ-035 first_n=1, count=3 -> results (1,0), (2,1), (3,7) in order, then exactly one sweep_done.
REQ-036 first_n=27, count=1, with res_ready held 0 for 20 cycles -> res_valid held with 27/111 stable; no it_go until after acceptance; sweep_done only after the handshake.
REQ-037 first_n=32'hFFFFFFFF, count=2 -> second value wraps to 0 and reports res_steps=FFFF, res_err=1, with no it_go for n=0.
REQ-038 Iterator stuck at it_dout=4 -> timeout result FFFF/err=1 after 65535 WAIT cycles; next value still loads.
REQ-039 count=0 -> sweep_done pulse two cycles after start with no it_go; reset asserted in WAIT -> IDLE with all outputs at reset values; start pulsed while busy -> ignored.
